// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

package prog_loader_pkg;

  // Loader sequencing states; RUN is the only state in which the core runs.
  typedef enum logic [2:0] {
    ST_HDR0 = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_RUN  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Image header is a 16-bit little-endian word count.
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = `DATAWIDTH / 8;

  // States in which the loader takes bytes from the source.
  function automatic logic is_loading(input state_e s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs a byte stream into little-endian words (first byte -> bits [7:0]).
// Latency: word_valid/word register one cycle after the last byte of a word.
// Backpressure: none; caller qualifies each byte with byte_en.
//
// Ports: clk/rst_n; clr drops any partial word; byte_en/byte_data deliver
// one byte; last_lane flags that the next byte completes a word;
// word_valid/word present the completed word for one cycle.
module byte_packer
  import prog_loader_pkg::*;
#(
  parameter int DATAW = `DATAWIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             byte_en,
  input  logic [7:0]       byte_data,
  output logic             last_lane,
  output logic             word_valid,
  output logic [DATAW-1:0] word
);

  localparam int BPW   = DATAW / 8;
  localparam int LANEW = $clog2(BPW);

  logic [LANEW-1:0] lane;
  // Earlier bytes of the current word; new bytes enter at the top so the
  // first byte ends up lowest once the word is complete.
  logic [DATAW-9:0] sh;

  assign last_lane = (lane == LANEW'(BPW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= '0;
      sh         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en && last_lane;
      if (clr) begin
        lane <= '0;
        sh   <= '0;
      end else if (byte_en) begin
        sh <= {byte_data, sh[DATAW-9:8]};
        if (last_lane) begin
          lane <= '0;
          word <= {byte_data, sh};
        end else begin
          lane <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot sequencer: holds the core in reset, loads a byte-stream image into IRAM.
// Latency: IRAM write 1 cycle after a word's last byte; core released 1 later.
// Backpressure: byte_ready only while loading; stalls on byte_valid gaps.
//
// Ports: clk/rst_n; byte_valid/byte_data/byte_ready source handshake;
// restart reloads from RUN or ERR; imem_we/imem_addr/imem_wdata IRAM write
// port; core_rst_n datapath reset; busy while loading; err on rejected image.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          DATAW = `DATAWIDTH,
  parameter int          ADDRW = `ADDRWIDTH,
  parameter int unsigned DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  input  logic             restart,
  output logic             imem_we,
  output logic [ADDRW-1:0] imem_addr,
  output logic [DATAW-1:0] imem_wdata,
  output logic             core_rst_n,
  output logic             busy,
  output logic             err
);

  state_e      state, nxt;
  logic [15:0] cnt;
  logic [15:0] widx;
  logic [15:0] hdr_n;
  logic        accept;
  logic        last_lane;
  logic        run_q;
  logic        clr;

  assign accept = byte_valid && byte_ready;
  // Full word count as it will stand once the second header byte lands.
  assign hdr_n  = {byte_data, cnt[7:0]};
  assign clr    = restart && ((state == ST_RUN) || (state == ST_ERR));

  always_comb begin
    nxt = state;
    case (state)
      ST_HDR0: if (accept) nxt = ST_HDR1;
      ST_HDR1: begin
        if (accept) begin
          if (hdr_n == 16'd0)                nxt = ST_RUN;
          else if ({16'd0, hdr_n} > DEPTH)   nxt = ST_ERR;
          else                               nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && last_lane && ((widx + 16'd1) == cnt)) nxt = ST_RUN;
      end
      ST_RUN:  if (restart) nxt = ST_HDR0;
      ST_ERR:  if (restart) nxt = ST_HDR0;
      default: nxt = ST_HDR0;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register. core_rst_n rises one cycle after entering RUN (the
  // last IRAM write lands first) but drops in the same cycle as leaving RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HDR0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      run_q      <= 1'b0;
      core_rst_n <= 1'b0;
    end else begin
      state      <= nxt;
      byte_ready <= is_loading(nxt);
      busy       <= is_loading(nxt);
      err        <= (nxt == ST_ERR);
      run_q      <= (nxt == ST_RUN);
      core_rst_n <= run_q && (nxt == ST_RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      widx      <= '0;
      imem_addr <= '0;
    end else if (clr) begin
      cnt  <= '0;
      widx <= '0;
    end else if (accept) begin
      case (state)
        ST_HDR0: cnt[7:0]  <= byte_data;
        ST_HDR1: cnt[15:8] <= byte_data;
        ST_DATA: begin
          if (last_lane) begin
            imem_addr <= ADDRW'({widx, 2'b00});
            widx      <= widx + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  byte_packer #(.DATAW(DATAW)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .byte_en    (accept && (state == ST_DATA)),
    .byte_data  (byte_data),
    .last_lane  (last_lane),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: hand-computed images and expected writes.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        restart = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;
  int acc   = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  prog_loader #(.DATAW(32), .ADDRW(32), .DEPTH(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Inputs only change at posedge+1, so the negedge sees stable values.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
    if (rst_n && byte_valid && byte_ready) acc++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte after 'gap' idle cycles and holds it until taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic rdy;
    logic got;
    repeat (gap) step();
    byte_valid = 1'b1;
    byte_data  = b;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      rdy = byte_ready;
      @(posedge clk);
      #1;
      if (rdy) got = 1'b1;
    end
    byte_valid = 1'b0;
    if (!got) check("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic check_write(input int idx, input logic [31:0] a, input logic [31:0] d);
    if (idx < wr_addr.size()) begin
      check($sformatf("wr%0d_addr", idx), wr_addr[idx], a);
      check($sformatf("wr%0d_data", idx), wr_data[idx], d);
    end else begin
      check($sformatf("wr%0d_missing", idx), 32'd0, 32'd1);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    acc = 0;
  endtask

  logic [7:0] img2 [0:9];

  initial begin
    img2[0] = 8'h02; img2[1] = 8'h00;
    img2[2] = 8'h13; img2[3] = 8'h00; img2[4] = 8'h00; img2[5] = 8'h00;
    img2[6] = 8'h93; img2[7] = 8'h00; img2[8] = 8'h10; img2[9] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    step();
    rst_n = 1'b1;
    step();

    // Two-word image, back-to-back bytes
    clear_log();
    send_byte(img2[0], 0);
    @(negedge clk);
    check("t1_busy_hdr", busy, 1);
    check("t1_ready_hdr", byte_ready, 1);
    step();
    for (int i = 1; i < 10; i++) send_byte(img2[i], 0);
    @(negedge clk);
    check("t1_last_we", imem_we, 1);
    check("t1_last_addr", imem_addr, 32'h4);
    check("t1_last_data", imem_wdata, 32'h0010_0093);
    check("t1_core_rst_k1", core_rst_n, 0);
    check("t1_busy_run", busy, 0);
    check("t1_ready_run", byte_ready, 0);
    @(negedge clk);
    check("t1_core_rst_k2", core_rst_n, 1);
    check("t1_we_k2", imem_we, 0);
    check("t1_wr_count", wr_addr.size(), 2);
    check_write(0, 32'h0, 32'h0000_0013);
    check_write(1, 32'h4, 32'h0010_0093);
    step();

    // Restart from RUN, one-word image
    clear_log();
    pulse_restart();
    @(negedge clk);
    check("t5_core_rst_low", core_rst_n, 0);
    check("t5_ready", byte_ready, 1);
    check("t5_busy", busy, 1);
    step();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    @(negedge clk);
    check("t5_core_rst_k1", core_rst_n, 0);
    @(negedge clk);
    check("t5_core_rst_k2", core_rst_n, 1);
    check("t5_wr_count", wr_addr.size(), 1);
    check_write(0, 32'h0, 32'hDEAD_BEEF);
    step();

    // Empty image: straight to RUN, no writes
    clear_log();
    pulse_restart();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    @(negedge clk);
    check("t2_we", imem_we, 0);
    check("t2_core_rst_k1", core_rst_n, 0);
    check("t2_busy", busy, 0);
    @(negedge clk);
    check("t2_core_rst_k2", core_rst_n, 1);
    check("t2_wr_count", wr_addr.size(), 0);
    step();

    // Same two-word image with random idle gaps on byte_valid
    clear_log();
    pulse_restart();
    for (int i = 0; i < 10; i++) send_byte(img2[i], $urandom_range(0, 2));
    repeat (2) @(negedge clk);
    check("t4_core_rst", core_rst_n, 1);
    check("t4_accepted", acc, 10);
    check("t4_wr_count", wr_addr.size(), 2);
    check_write(0, 32'h0, 32'h0000_0013);
    check_write(1, 32'h4, 32'h0010_0093);
    step();

    // Oversized image (1025 words) is rejected
    clear_log();
    pulse_restart();
    send_byte(8'h01, 0); send_byte(8'h04, 0);
    @(negedge clk);
    check("t3_err", err, 1);
    check("t3_ready", byte_ready, 0);
    check("t3_busy", busy, 0);
    repeat (4) @(negedge clk);
    check("t3_core_rst", core_rst_n, 0);
    check("t3_no_write", wr_addr.size(), 0);
    step();
    pulse_restart();
    @(negedge clk);
    check("t3_err_clr", err, 0);
    check("t3_ready_clr", byte_ready, 1);
    step();

    // Exactly DEPTH words is accepted; then abort with rst_n mid-word
    send_byte(8'h00, 0); send_byte(8'h04, 0);
    @(negedge clk);
    check("t6_err_depth", err, 0);
    check("t6_busy_depth", busy, 1);
    step();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", byte_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_core", core_rst_n, 0);
    check("t6_rst_we", imem_we, 0);
    check("t6_rst_addr", imem_addr, 0);
    check("t6_rst_wdata", imem_wdata, 0);
    check("t6_no_write", wr_addr.size(), 0);
    step();
    rst_n = 1'b1;
    step();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    repeat (2) @(negedge clk);
    check("t6_core_rst", core_rst_n, 1);
    check("t6_wr_count", wr_addr.size(), 1);
    check_write(0, 32'h0, 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time sequencer for the single-cycle core. It holds the datapath in reset and receives a program image as a byte stream. It packs the bytes into 32-bit little-endian words and writes them into instruction RAM, then releases the core. It sits between the external byte source (UART/debug bridge), the instruction RAM write port, and the core's reset input. The instruction RAM is the memory the datapath reads through `instr_addr`/`instr`.

## Interface
- `DATAW`, default 32: instruction word width; must equal `` `datawidth ``.
- `ADDRW`, default 32: instruction RAM byte-address width; must equal `` `addrwidth ``.
- `DEPTH`, default 1024: instruction RAM capacity in words; an image longer than this is rejected.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `byte_valid` in 1: source has a byte on `byte_data`.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle; a transfer occurs when `byte_valid && byte_ready`.
- `restart` in 1: single-cycle pulse; reload a new image.
- `imem_we` out 1: instruction RAM write strobe, one cycle per word.
- `imem_addr` out ADDRW: byte address of the word being written (word index × 4).
- `imem_wdata` out DATAW: packed word.
- `core_rst_n` out 1: reset to the datapath; low holds the core in reset.
- `busy` out 1: a load is in progress (HDR0/HDR1/DATA).
- `err` out 1: the image was rejected.

## Operation
- States: HDR0, HDR1, DATA, RUN, ERR. After `rst_n` the block enters HDR0.
- HDR0: accept a byte → `cnt[7:0]`, then go to HDR1.
- HDR1: accept a byte → `cnt[15:8]`, then:
  - N = 0 → RUN.
  - N > DEPTH → ERR.
  - otherwise → DATA.
- DATA: bytes accumulate little-endian; the first byte lands in bits [7:0].
  - On the 4th byte, register the word and pulse `imem_we` with `imem_addr` = `widx`<<2, then increment `widx`.
  - When `widx` reaches N, go to RUN.
- RUN: `byte_ready`=0 and the core runs. A `restart` goes to HDR0 and clears `cnt`, `widx` and the byte lane.
- ERR: `err`=1 and `byte_ready`=0; the core stays in reset. `restart` goes to HDR0 and clears `err`.
- `byte_ready` = 1 exactly in HDR0, HDR1 and DATA. Gaps in `byte_valid` stall the sequence with no loss.
- `restart` is ignored in HDR0/HDR1/DATA. A mid-load abort requires `rst_n`.
- Arithmetic: `cnt` is 16 bits unsigned and `widx` is 16 bits. The comparison against DEPTH is unsigned. `imem_addr` is zero-extended to ADDRW.

## Timing
- Reset values: `core_rst_n`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `byte_ready`=0, `busy`=0, `err`=0, state=HDR0.
- All outputs are registered.
  - `byte_ready` and `busy` reflect the current state.
  - `core_rst_n` is a flop driven as (next state == RUN) and delayed one further cycle.
- Byte accepted at cycle k:
  - Lane update is visible at k+1.
  - If it is the 4th byte of a word, `imem_we`=1 at k+1 with that word's address and data.
- Last byte of the last word accepted at cycle k:
  - `imem_we`=1 and state=RUN at k+1.
  - `core_rst_n`=1 at k+2. The final write completes before the core leaves reset.
- N=0: HDR1 byte at k → RUN at k+1, `core_rst_n`=1 at k+2.
- `restart` asserted at cycle k in RUN:
  - State=HDR0 and `core_rst_n`=0 at k+1.
  - `byte_ready`=1 at k+1.
- `rst_n` asserted mid-load: all outputs return to reset values immediately (asynchronously). Any partial word is discarded; words already written stay in RAM.

## Structure
- Shared package/defines: state encodings, the header byte count (2), and bytes-per-word (DATAW/8). Width macros are reused from the existing `` `datawidth ``/`` `addrwidth `` defines.
- One sub-module, `byte_packer`, assembles the 4-byte shift and lane count and outputs `word_valid`/`word`. The FSM, counters and `core_rst_n` stay in `prog_loader`.

## Test plan
- Stream 02 00, then bytes 13 00 00 00, then 93 00 10 00:
  - two `imem_we` pulses, addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093.
  - `core_rst_n` rises 2 cycles after the last byte.
- Header 00 00: no `imem_we`; `core_rst_n`=1 two cycles after the 2nd header byte.
- With DEPTH=1024, header 01 04 (N=1025): `err`=1, `byte_ready`=0, `core_rst_n` stays 0. Then `restart` → `err`=0 and HDR0.
- Same image as the first test with `byte_valid` toggling 1-0-0-1 randomly: identical writes, and no byte is accepted while `byte_ready`=0.
- `restart` pulse in RUN: `core_rst_n`=0 next cycle; the new 1-word image writes addr 0x0 and the core is released again.
- `rst_n` low after 2 data bytes: all outputs are at reset values within that cycle; after release, a full reload produces a correct word at addr 0x0.
